// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of both master ports plus the memory port.
// slave = arbiter view, master = requester/memory environment view.
interface mem_arbiter_if #(
  parameter int DW = 16,
  parameter int AW = 16
);
  logic          m0_read;
  logic          m0_write;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic [DW-1:0] m0_rdata;
  logic          m0_ack;
  logic          m1_read;
  logic          m1_write;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic [DW-1:0] m1_rdata;
  logic          m1_ack;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          busy;

  modport slave (
    input  m0_read, m0_write, m0_addr, m0_wdata,
    output m0_rdata, m0_ack,
    input  m1_read, m1_write, m1_addr, m1_wdata,
    output m1_rdata, m1_ack,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack,
    output busy
  );

  modport master (
    output m0_read, m0_write, m0_addr, m0_wdata,
    input  m0_rdata, m0_ack,
    output m1_read, m1_write, m1_addr, m1_wdata,
    input  m1_rdata, m1_ack,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ack,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between CPU (port 0) and port 1.
// Define MEM_ARBITER_RR_EN for round-robin; default is fixed priority.
module mem_arbiter #(
  parameter int DW = 16,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_b,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          busy_q, busy_d;
  logic          req0, req1, grant1;

  assign req0 = bus.m0_read | bus.m0_write;
  assign req1 = bus.m1_read | bus.m1_write;

`ifdef MEM_ARBITER_RR_EN
  // port 1 wins if alone, or on contention when port 0 was served last
  assign grant1 = req1 & (~req0 | ~last_q);
`else
  // port 0 always wins; port 1 only when port 0 is quiet
  assign grant1 = req1 & ~req0;
`endif

  // next-state: arbitrate in IDLE, wait for memory in BUSY, pulse in ACK
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          owner_d = grant1;
          state_d = BUSY;
          if (grant1) begin
            rd_d    = bus.m1_read & ~bus.m1_write;
            wr_d    = bus.m1_write;
            addr_d  = bus.m1_addr;
            wdata_d = bus.m1_wdata;
          end else begin
            rd_d    = bus.m0_read & ~bus.m0_write;
            wr_d    = bus.m0_write;
            addr_d  = bus.m0_addr;
            wdata_d = bus.m0_wdata;
          end
        end else begin
          rd_d = 1'b0;
          wr_d = 1'b0;
        end
      end
      BUSY: begin
        if (bus.mem_ack) begin
          if (rd_q) begin
            if (owner_q) rdata1_d = bus.mem_rdata;
            else         rdata0_d = bus.mem_rdata;
          end
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          last_d  = owner_q;
          ack0_d  = ~owner_q;
          ack1_d  = owner_q;
          state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.mem_read  = rd_q;
  assign bus.mem_write = wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.m0_rdata  = rdata0_q;
  assign bus.m1_rdata  = rdata1_q;
  assign bus.m0_ack    = ack0_q;
  assign bus.m1_ack    = ack1_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter
// against a memory environment and a transaction-level reference model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.DW(16), .AW(16)) bus ();

  mem_arbiter #(.DW(16), .AW(16)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // memory environment state
  logic [15:0] memarr [int];
  int lat = 1;
  bit lat_rand = 1'b0;
  int spur_cnt = 0;
  int spur_done = 0;

  // reference model state
  logic [15:0] refm [int];
  bit ref_last = 1'b1;
  int got_order [$];

  logic        tx_we   [2][16];
  logic [15:0] tx_addr [2][16];
  logic [15:0] tx_wd   [2][16];

  function automatic logic [15:0] mem_init(input int a);
    logic [15:0] v;
    v = 16'(a) ^ 16'h5A5A;
    return v;
  endfunction

  function automatic logic [15:0] ref_rd(input int a);
    if (refm.exists(a)) return refm[a];
    return mem_init(a);
  endfunction

  // memory: acks an access after a latency counted from the strobe
  initial begin : env
    int a;
    int cnt;
    int cur;
    cnt = 0;
    cur = 1;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_ack = 1'b0;
      if (spur_cnt != spur_done) begin
        bus.mem_rdata = 16'hDEAD;
        bus.mem_ack = 1'b1;
        spur_done++;
      end else if (bus.mem_read || bus.mem_write) begin
        cnt++;
        if (cnt == 1)
          cur = lat_rand ? int'($urandom_range(4, 1)) : lat;
        if (cnt >= cur) begin
          a = int'(bus.mem_addr);
          if (bus.mem_write) memarr[a] = bus.mem_wdata;
          else bus.mem_rdata = memarr.exists(a) ? memarr[a] : mem_init(a);
          bus.mem_ack = 1'b1;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic set_req(input int p, input bit rd, input bit wr,
                         input logic [15:0] a, input logic [15:0] d);
    if (p == 0) begin
      bus.m0_read = rd; bus.m0_write = wr;
      bus.m0_addr = a;  bus.m0_wdata = d;
    end else begin
      bus.m1_read = rd; bus.m1_write = wr;
      bus.m1_addr = a;  bus.m1_wdata = d;
    end
  endtask

  // one master: issues its queued accesses back to back
  task automatic drive_port(input int p, input int n);
    logic got;
    logic oth;
    logic [15:0] rd;
    logic [15:0] exp;
    for (int i = 0; i < n; i++) begin
      set_req(p, !tx_we[p][i], tx_we[p][i], tx_addr[p][i], tx_wd[p][i]);
      got = 1'b0;
      oth = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
        @(negedge clk);
        got = (p == 0) ? bus.m0_ack : bus.m1_ack;
        oth = (p == 0) ? bus.m1_ack : bus.m0_ack;
      end
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL ack_timeout port %0d access %0d: no ack in 40 cycles", p, i);
      end else begin
        got_order.push_back(p);
        ref_last = p[0];
        checks++;
        if (oth !== 1'b0) begin
          errors++;
          $display("FAIL dual_ack port %0d: other ack=%b required 0", p, oth);
        end
        if (tx_we[p][i]) begin
          refm[int'(tx_addr[p][i])] = tx_wd[p][i];
        end else begin
          rd = (p == 0) ? bus.m0_rdata : bus.m1_rdata;
          exp = ref_rd(int'(tx_addr[p][i]));
          checks++;
          if (rd !== exp) begin
            errors++;
            $display("FAIL rdata port %0d addr %h: got %h required %h",
                     p, tx_addr[p][i], rd, exp);
          end
        end
      end
    end
    set_req(p, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  // both ports contend; expected grant order derived from arbitration rule
  task automatic run_contention(input int n0, input int n1);
    int a;
    int b;
    int pk;
    bit l;
    int expq [$];
    got_order.delete();
    a = n0;
    b = n1;
    l = ref_last;
    while (a > 0 || b > 0) begin
      if (a > 0 && b > 0) begin
`ifdef MEM_ARBITER_RR_EN
        pk = (l == 1'b0) ? 1 : 0;
`else
        pk = 0;
`endif
      end else begin
        pk = (a > 0) ? 0 : 1;
      end
      expq.push_back(pk);
      l = pk[0];
      if (pk == 0) a--; else b--;
    end
    @(negedge clk);
    fork
      drive_port(0, n0);
      drive_port(1, n1);
    join
    checks++;
    if (got_order.size() != expq.size()) begin
      errors++;
      $display("FAIL order_len: got %0d required %0d",
               got_order.size(), expq.size());
    end else begin
      foreach (expq[i]) begin
        checks++;
        if (got_order[i] != expq[i]) begin
          errors++;
          $display("FAIL grant_order[%0d]: got port %0d required port %0d",
                   i, got_order[i], expq[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    set_req(0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_req(1, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.mem_read, bus.mem_write, bus.busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_strobes: rd/wr/busy=%b required 000",
               {bus.mem_read, bus.mem_write, bus.busy});
    end
    checks++;
    if ({bus.m0_ack, bus.m1_ack} !== 2'b00) begin
      errors++;
      $display("FAIL reset_acks: got %b required 00", {bus.m0_ack, bus.m1_ack});
    end
    checks++;
    if ({bus.m0_rdata, bus.m1_rdata, bus.mem_addr, bus.mem_wdata} !== 64'h0) begin
      errors++;
      $display("FAIL reset_data: got %h required 0",
               {bus.m0_rdata, bus.m1_rdata, bus.mem_addr, bus.mem_wdata});
    end
    @(negedge clk);
    rst_b = 1'b1;
    ref_last = 1'b1;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    lat = 1;
    memarr[16] = 16'hBEEF;
    refm[16] = 16'hBEEF;
    set_req(0, 1'b1, 1'b0, 16'h0010, 16'h0);
    @(posedge clk); #1;
    checks++;
    if ({bus.mem_read, bus.mem_write, bus.busy, bus.m0_ack} !== 4'b1010 ||
        bus.mem_addr !== 16'h0010) begin
      errors++;
      $display("FAIL sr_strobe: rd/wr/busy/ack=%b addr=%h required 1010 0010",
               {bus.mem_read, bus.mem_write, bus.busy, bus.m0_ack}, bus.mem_addr);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.mem_read, bus.m0_ack, bus.m1_ack} !== 3'b010) begin
      errors++;
      $display("FAIL sr_ack: rd/ack0/ack1=%b required 010",
               {bus.mem_read, bus.m0_ack, bus.m1_ack});
    end
    checks++;
    if (bus.m0_rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL sr_rdata: got %h required beef", bus.m0_rdata);
    end
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(posedge clk); #1;
    checks++;
    if ({bus.m0_ack, bus.m1_ack, bus.busy, bus.mem_read} !== 4'b0000) begin
      errors++;
      $display("FAIL sr_done: ack0/ack1/busy/rd=%b required 0000",
               {bus.m0_ack, bus.m1_ack, bus.busy, bus.mem_read});
    end
    ref_last = 1'b0;
  endtask

  task automatic test_write_lat3();
    @(negedge clk);
    lat = 3;
    set_req(1, 1'b0, 1'b1, 16'h0200, 16'h1234);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.mem_write, bus.mem_read, bus.m1_ack} !== 3'b100 ||
          bus.mem_addr !== 16'h0200 || bus.mem_wdata !== 16'h1234) begin
        errors++;
        $display("FAIL wr_hold cycle %0d: wr/rd/ack=%b addr=%h wdata=%h required 100 0200 1234",
                 k, {bus.mem_write, bus.mem_read, bus.m1_ack},
                 bus.mem_addr, bus.mem_wdata);
      end
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.m1_ack, bus.m0_ack, bus.mem_write} !== 3'b100) begin
      errors++;
      $display("FAIL wr_ack: ack1/ack0/wr=%b required 100",
               {bus.m1_ack, bus.m0_ack, bus.mem_write});
    end
    @(negedge clk);
    set_req(1, 1'b0, 1'b0, 16'h0, 16'h0);
    @(posedge clk); #1;
    checks++;
    if ({bus.busy, bus.m1_ack} !== 2'b00) begin
      errors++;
      $display("FAIL wr_idle: busy/ack1=%b required 00", {bus.busy, bus.m1_ack});
    end
    checks++;
    if (!memarr.exists(32'h200) || memarr[32'h200] !== 16'h1234) begin
      errors++;
      $display("FAIL wr_mem: memory at 0200 not 1234");
    end
    refm[32'h200] = 16'h1234;
    ref_last = 1'b1;
    lat = 1;
  endtask

  task automatic test_contention();
    for (int i = 0; i < 4; i++) begin
      for (int p = 0; p < 2; p++) begin
        tx_we[p][i] = 1'b0;
        tx_addr[p][i] = 16'($urandom_range(7, 0));
        tx_wd[p][i] = 16'h0;
      end
    end
    run_contention(4, 4);
  endtask

  task automatic test_rw_same();
    int n0;
    int n1;
    n0 = 0;
    n1 = 0;
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 16'h0030, 16'h00FF);
    @(posedge clk); #1;
    checks++;
    if ({bus.mem_write, bus.mem_read} !== 2'b10 || bus.mem_wdata !== 16'h00FF) begin
      errors++;
      $display("FAIL rw_strobe: wr/rd=%b wdata=%h required 10 00ff",
               {bus.mem_write, bus.mem_read}, bus.mem_wdata);
    end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (bus.m0_ack === 1'b1) n0++;
      if (bus.m1_ack === 1'b1) n1++;
      if (bus.m0_ack === 1'b1) begin
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 16'h0, 16'h0);
      end
    end
    set_req(0, 1'b0, 1'b0, 16'h0, 16'h0);
    checks++;
    if (n0 != 1 || n1 != 0) begin
      errors++;
      $display("FAIL rw_acks: ack0 count %0d ack1 count %0d required 1 0", n0, n1);
    end
    checks++;
    if (!memarr.exists(32'h30) || memarr[32'h30] !== 16'h00FF) begin
      errors++;
      $display("FAIL rw_mem: memory at 0030 not 00ff");
    end
    refm[32'h30] = 16'h00FF;
    ref_last = 1'b0;
  endtask

  task automatic test_reset_busy();
    int bad;
    bad = 0;
    @(negedge clk);
    lat = 5;
    set_req(0, 1'b1, 1'b0, 16'h0040, 16'h0);
    @(posedge clk); #1;
    checks++;
    if ({bus.busy, bus.mem_read} !== 2'b11) begin
      errors++;
      $display("FAIL rb_busy: busy/rd=%b required 11", {bus.busy, bus.mem_read});
    end
    #2;
    rst_b = 1'b0;
    #1;
    checks++;
    if ({bus.mem_read, bus.mem_write, bus.busy} !== 3'b000) begin
      errors++;
      $display("FAIL rb_async: rd/wr/busy=%b required 000",
               {bus.mem_read, bus.mem_write, bus.busy});
    end
    set_req(0, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.m0_ack !== 1'b0 || bus.m1_ack !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rb_noack: %0d cycles with ack required 0", bad);
    end
    @(negedge clk);
    rst_b = 1'b1;
    ref_last = 1'b1;
    lat = 1;
    tx_we[0][0] = 1'b0; tx_addr[0][0] = 16'h0005; tx_wd[0][0] = 16'h0;
    tx_we[1][0] = 1'b0; tx_addr[1][0] = 16'h0006; tx_wd[1][0] = 16'h0;
    run_contention(1, 1);
  endtask

  task automatic test_spurious();
    int bad;
    logic [15:0] exp;
    bad = 0;
    @(negedge clk);
    spur_cnt++;
    repeat (3) begin
      @(posedge clk); #1;
      if ({bus.m0_ack, bus.m1_ack, bus.busy, bus.mem_read, bus.mem_write} !== 5'b0)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL spur_idle: %0d cycles with ack/busy/strobe required 0", bad);
    end
    @(negedge clk);
    set_req(1, 1'b1, 1'b0, 16'h0077, 16'h0);
    exp = ref_rd(32'h77);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (bus.m1_ack !== 1'b1 || bus.m1_rdata !== exp) begin
      errors++;
      $display("FAIL spur_after: ack1=%b rdata=%h required 1 %h",
               bus.m1_ack, bus.m1_rdata, exp);
    end
    @(negedge clk);
    set_req(1, 1'b0, 1'b0, 16'h0, 16'h0);
    ref_last = 1'b1;
  endtask

  task automatic test_random();
    int n0;
    int n1;
    lat_rand = 1'b1;
    for (int r = 0; r < 20; r++) begin
      n0 = int'($urandom_range(5, 0));
      n1 = int'($urandom_range(5, 0));
      if (n0 == 0 && n1 == 0) n1 = 1;
      for (int i = 0; i < 6; i++) begin
        for (int p = 0; p < 2; p++) begin
          tx_we[p][i] = 1'($urandom_range(1, 0));
          tx_addr[p][i] = 16'($urandom_range(7, 0));
          tx_wd[p][i] = 16'($urandom);
        end
      end
      run_contention(n0, n1);
    end
    lat_rand = 1'b0;
  endtask

  initial begin : main
    test_reset();
    test_single_read();
    test_write_lat3();
    test_contention();
    test_rw_same();
    test_reset_busy();
    test_spurious();
    test_random();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single memory port between the CPU (port 0) and a secondary master (port 1, loader/DMA/debug). It serialises accesses, forwards one request at a time to memory, waits for the memory acknowledge, and returns a one-cycle acknowledge plus captured read data to the winning master. It sits between the CPU's `read`/`write`/`address`/`mem_out`/`mem_in` pins and the memory model.

## Interface
- `DW`, default 16: data width.
- `AW`, default 16: address width.

- `clk`  in  1  system clock, rising edge.
- `rst_b`  in  1  asynchronous active-low reset.
- `m0_read`, `m0_write`  in  1 each  port 0 request, level, held until acknowledged.
- `m0_addr`  in  AW  port 0 address.
- `m0_wdata`  in  DW  port 0 write data.
- `m0_rdata`  out  DW  port 0 read data, valid while `m0_ack`=1.
- `m0_ack`  out  1  port 0 completion pulse.
- `m1_read`, `m1_write`, `m1_addr`, `m1_wdata`, `m1_rdata`, `m1_ack`: same as port 0, for port 1.
- `mem_read`, `mem_write`  out  1 each  registered memory strobes.
- `mem_addr`  out  AW  registered memory address.
- `mem_wdata`  out  DW  registered write data.
- `mem_rdata`  in  DW  memory read data, valid with `mem_ack`.
- `mem_ack`  in  1  memory completion, one or more cycles after the strobe.
- `busy`  out  1  high in BUSY or ACK.

## Operation
- States: IDLE, BUSY, ACK. 1-bit `owner` (granted port) and 1-bit `last` (last served port).
- IDLE: if any port requests, choose winner (see Configuration), latch its addr/wdata/read/write into `mem_*`, set `owner`, go to BUSY. No request: stay IDLE, `mem_*` strobes 0.
- Request with both `read` and `write` high is treated as a write.
- BUSY: hold `mem_*` stable. On sampled `mem_ack`=1: capture `mem_rdata` into the owner's rdata register, clear strobes, set `last`=`owner`, go to ACK. Requests from either port are ignored.
- ACK: `mN_ack`=1 for `owner` only, for exactly one cycle. Go to IDLE unconditionally, with no arbitration in ACK.
- Master rule: deassert the request at the edge that samples `mN_ack`=1, or present a new access. The arbiter samples it in the following IDLE cycle.
- `mN_rdata` holds its last captured value until the next read completes for that port. It is undefined for writes, and the implementation keeps the previous value.
- Reset values: state IDLE, `owner`=0, `last`=1, all `mem_*` and `mN_rdata` 0, both acks 0, `busy` 0.
- Reset mid-access: strobes drop asynchronously, no ack is issued, and the access is lost. Memory must tolerate an abandoned strobe.

## Timing
- Request high before edge E0 in IDLE: `mem_*` valid after E0.
- `mem_ack` sampled at edge E1 (earliest E0+1), then `mN_ack` is high from E1 to E1+1.
- Minimum latency, request to ack: 2 cycles. Minimum throughput: one access per 3 cycles.
- `mem_ack` in IDLE or ACK is ignored.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- `MEM_ARBITER_RR_EN` defined: round-robin. On simultaneous requests in IDLE, the port ≠ `last` wins, so two contending masters alternate.
- Not defined: fixed priority, port 0 (CPU) always wins. `last` is still maintained but not used. Port 1 can starve.

## Test plan
- Single read: m0_read, m0_addr=0x0010, memory returns 0xBEEF with ack 1 cycle after strobe -> `mem_read` high 1 cycle, `m0_ack` pulse 2 cycles after request edge, `m0_rdata`=0xBEEF, `m1_ack` stays 0.
- Write with 3-cycle memory latency: m1_write, addr=0x0200, wdata=0x1234 -> `mem_write`/`mem_addr`/`mem_wdata` stable for 3 cycles, `m1_ack` 1 cycle after `mem_ack`, `busy` low after.
- Contention, RR build: both ports request reads continuously for 4 accesses -> grant order 0,1,0,1. Fixed build: 0,0,0,0 while port 0 holds its request.
- Read+write on same port simultaneously: m0_read=m0_write=1, wdata=0x00FF -> `mem_write`=1, `mem_read`=0, one ack.
- Reset asserted in BUSY: strobes 0 immediately, no ack. After release, a fresh m0 read to 0x0005 completes normally and port 0 wins first contention.
- Spurious `mem_ack` in IDLE: no ack to either port, state remains IDLE.
